maxpool_engine: RTL

2×2, stride-2 max-pooling engine driven by the instruction decoder's `mp_rst` / `mp_ifaddr` / `mp_ofaddr` / `mp_done` handshake.
- On each start pulse it reads a CHW feature map from the shared data memory, takes the signed maximum of each 2×2 window, and writes the pooled map back.
- It then pulses `mp_done`, which releases the decoder from its MPSOF wait.
- It sits beside the FC and CV engines on the data-memory port.

---
 rtl/maxpool_engine_pkg.sv | 18 +
 rtl/maxpool_engine_mp_addr_gen.sv | 81 ++++++++
 rtl/maxpool_engine.sv | 115 +++++++++++
 3 files changed

// File: rtl/maxpool_engine_pkg.sv
// Shared definitions for the 2x2 stride-2 max-pooling engine.
// State encodings and default element/address widths.
package maxpool_engine_pkg;

  localparam int unsigned MP_DATA_W = 16;
  localparam int unsigned MP_ADDR_W = 27;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRd,
    StWait,
    StWr,
    StNext,
    StDone
  } mp_state_e;

endpackage

// File: rtl/maxpool_engine_mp_addr_gen.sv
// Incremental tap/output address generator for the max-pooling engine.
// Walks ox (innermost), oy, then c using adds only.
module mp_addr_gen
  import maxpool_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = MP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              advance,
  input  logic [1:0]        tap,
  input  logic [ADDR_W-1:0] ifaddr,
  input  logic [ADDR_W-1:0] ofaddr,
  input  logic [10:0]       ch,
  input  logic [12:0]       h,
  input  logic [12:0]       w,
  output logic [ADDR_W-1:0] tap_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              last_out
);

  logic [11:0]       ho, wo;
  logic [11:0]       ox_q, oy_q;
  logic [10:0]       c_q;
  logic [ADDR_W-1:0] row_base_q, col_base_q, out_addr_q;
  logic [ADDR_W-1:0] w_ext, next_row, next_ch;
  logic              last_ox, last_oy, last_c;

  assign ho       = h[12:1];
  assign wo       = w[12:1];
  assign w_ext    = ADDR_W'(w);
  assign next_row = row_base_q + ADDR_W'({w, 1'b0});
  // An odd input height leaves one unread row before the next channel starts.
  assign next_ch  = next_row + (h[0] ? w_ext : '0);

  assign tap_addr = col_base_q + (tap[1] ? w_ext : '0) + ADDR_W'(tap[0]);
  assign out_addr = out_addr_q;

  assign last_ox  = (ox_q == wo - 12'd1);
  assign last_oy  = (oy_q == ho - 12'd1);
  assign last_c   = (c_q == ch - 11'd1);
  assign last_out = last_ox && last_oy && last_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      ox_q       <= '0;
      oy_q       <= '0;
      c_q        <= '0;
      row_base_q <= '0;
      col_base_q <= '0;
      out_addr_q <= '0;
    end else if (init) begin
      ox_q       <= '0;
      oy_q       <= '0;
      c_q        <= '0;
      row_base_q <= ifaddr;
      col_base_q <= ifaddr;
      out_addr_q <= ofaddr;
    end else if (advance) begin
      out_addr_q <= out_addr_q + ADDR_W'(1);
      if (!last_ox) begin
        ox_q       <= ox_q + 12'd1;
        col_base_q <= col_base_q + ADDR_W'(2);
      end else begin
        ox_q <= '0;
        if (!last_oy) begin
          oy_q       <= oy_q + 12'd1;
          row_base_q <= next_row;
          col_base_q <= next_row;
        end else begin
          oy_q       <= '0;
          c_q        <= c_q + 11'd1;
          row_base_q <= next_ch;
          col_base_q <= next_ch;
        end
      end
    end
  end

endmodule

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 signed max-pooling engine on the shared data-memory port.
// Started by mp_rst, finishes with a one-cycle mp_done pulse.
module maxpool_engine
  import maxpool_engine_pkg::*;
#(
  parameter int unsigned DATA_W = MP_DATA_W,
  parameter int unsigned ADDR_W = MP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mp_rst,
  input  logic [ADDR_W-1:0] mp_ifaddr,
  input  logic [ADDR_W-1:0] mp_ofaddr,
  input  logic [10:0]       mp_C,
  input  logic [12:0]       mp_H,
  input  logic [12:0]       mp_W,
  output logic              mp_done,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_gnt
);

  mp_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ifaddr_q, ofaddr_q;
  logic [10:0]       c_q;
  logic [12:0]       h_q, w_q;
  logic [1:0]        tap_q;
  logic [DATA_W-1:0] acc_q;
  logic              last_out, empty_job, take;

  assign empty_job = (c_q == '0) || (h_q < 13'd2) || (w_q < 13'd2);
  assign take      = (tap_q == 2'd0) || ($signed(mem_rd_data) > $signed(acc_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StIdle;
      StInit:  state_d = empty_job ? StDone : StRd;
      StRd:    if (mem_rd_gnt) state_d = StWait;
      StWait:  if (mem_rd_valid) state_d = (tap_q == 2'd3) ? StWr : StRd;
      StWr:    if (mem_wr_gnt) state_d = StNext;
      StNext:  state_d = last_out ? StDone : StRd;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A new start always wins, aborting whatever job is in flight.
    if (mp_rst) state_d = StInit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifaddr_q <= '0;
      ofaddr_q <= '0;
      c_q      <= '0;
      h_q      <= '0;
      w_q      <= '0;
      tap_q    <= '0;
      acc_q    <= '0;
    end else begin
      if (mp_rst) begin
        ifaddr_q <= mp_ifaddr;
        ofaddr_q <= mp_ofaddr;
        c_q      <= mp_C;
        h_q      <= mp_H;
        w_q      <= mp_W;
      end
      if (state_q == StInit) begin
        tap_q <= '0;
      end else if (state_q == StWait && mem_rd_valid) begin
        tap_q <= tap_q + 2'd1;
        if (take) acc_q <= mem_rd_data;
      end
    end
  end

  always_comb begin
    mem_rd_req  = (state_q == StRd);
    mem_wr_req  = (state_q == StWr);
    mp_done     = (state_q == StDone);
    mem_wr_data = acc_q;
  end

  mp_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (state_q == StInit),
    .advance  (state_q == StNext),
    .tap      (tap_q),
    .ifaddr   (ifaddr_q),
    .ofaddr   (ofaddr_q),
    .ch       (c_q),
    .h        (h_q),
    .w        (w_q),
    .tap_addr (mem_rd_addr),
    .out_addr (mem_wr_addr),
    .last_out (last_out)
  );

endmodule
